// File: rtl/life_pkg.sv
// Shared types and board geometry for the 8x8 toroidal Game of Life sequencer.
package life_pkg;

  localparam int BOARD_W  = 64;
  localparam int NUM_ROWS = 8;
  localparam int NUM_COLS = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    COMMIT
  } seq_state_t;

  typedef logic [BOARD_W-1:0] board_t;

endpackage

// File: rtl/life_tick_gen.sv
// Free-run generation-rate counter: emits a one-cycle tick every max(period_cycles,1) clocks while run is high.
module life_tick_gen #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [PERIOD_W-1:0] period_cycles,
  output logic                tick
);

  localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

  logic [PERIOD_W-1:0] count;
  logic [PERIOD_W-1:0] last;

  // A period of zero behaves like one; comparing with >= lets a shrunk period wrap at once.
  assign last = (period_cycles == '0) ? '0 : period_cycles - ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (!run) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (count >= last) begin
      count <= '0;
      tick  <= 1'b1;
    end else begin
      count <= count + ONE;
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/life_sequencer.sv
// Board owner and step/run controller for the Game of Life engine.
// Optional auto-halt on still-life or extinction is enabled by defining LIFE_AUTO_HALT_EN.
module life_sequencer
  import life_pkg::*;
#(
  parameter int PERIOD_W = 24,
  parameter int GEN_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_valid,
  input  logic [BOARD_W-1:0]  load_bits,
  output logic                load_ready,
  input  logic                run,
  input  logic                step,
  input  logic [PERIOD_W-1:0] period_cycles,
  output logic [BOARD_W-1:0]  engine_current,
  output logic                engine_update,
  input  logic [BOARD_W-1:0]  engine_next,
  output logic [BOARD_W-1:0]  board_bits,
  output logic                gen_done,
  output logic [GEN_W-1:0]    gen_count,
  output logic                stable,
  output logic                extinct
);

  localparam logic [GEN_W-1:0] GEN_ONE = GEN_W'(1);

  seq_state_t state;
  logic       tick;
  logic       pending;
  logic       tick_eff;
  logic       pending_eff;

  life_tick_gen #(
    .PERIOD_W(PERIOD_W)
  ) u_tick_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .period_cycles(period_cycles),
    .tick         (tick)
  );

`ifdef LIFE_AUTO_HALT_EN
  logic halted;
  logic run_q;

  assign tick_eff    = tick & ~halted;
  assign pending_eff = pending & ~halted;

  // Halt latches on a still-life or dead commit; a fresh load or a new run request resumes free-run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      run_q <= run;
      if (state == COMMIT && (engine_next == board_bits || engine_next == '0)) begin
        halted <= 1'b1;
      end else if ((state == IDLE && load_valid) || (run && !run_q)) begin
        halted <= 1'b0;
      end
    end
  end
`else
  assign tick_eff    = tick;
  assign pending_eff = pending;
`endif

  assign load_ready     = (state == IDLE);
  assign engine_current = board_bits;

  // Ticks that land while a generation is in flight are remembered once and never stacked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      board_bits    <= '0;
      gen_count     <= '0;
      stable        <= 1'b0;
      extinct       <= 1'b1;
      engine_update <= 1'b0;
      gen_done      <= 1'b0;
      pending       <= 1'b0;
    end else begin
      engine_update <= 1'b0;
      gen_done      <= 1'b0;

      if (!run) begin
        pending <= 1'b0;
`ifdef LIFE_AUTO_HALT_EN
      end else if (halted) begin
        pending <= 1'b0;
`endif
      end else if (tick_eff && state != IDLE) begin
        pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (load_valid) begin
            board_bits <= load_bits;
            gen_count  <= '0;
            stable     <= 1'b0;
            extinct    <= (load_bits == '0);
            pending    <= 1'b0;
          end else if (step || pending_eff || tick_eff) begin
            state         <= ISSUE;
            engine_update <= 1'b1;
            pending       <= 1'b0;
          end
        end

        ISSUE: begin
          state <= COMMIT;
        end

        COMMIT: begin
          board_bits <= engine_next;
          stable     <= (engine_next == board_bits);
          extinct    <= (engine_next == '0);
          gen_done   <= 1'b1;
          if (gen_count != '1) begin
            gen_count <= gen_count + GEN_ONE;
          end
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
